ethernet_rx_framer: RTL

Parametrised MII receive framer: the next generation of the team's nibble-to-byte MII receiver. Strips preamble/SFD and packs frame bytes into words of `DATA_BYTES` lanes with keep/SOF/EOF markers. Reports per-frame length and error status on the EOF beat. Sits between the PHY MII pins and the MAC receive path, all in the `eth_rx_clk` domain.

---
 rtl/ethernet_rx_framer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_rx_framer.sv
// MII receive framer: strips preamble/SFD and packs frame bytes into DATA_BYTES-lane beats with SOF/EOF, length and status.
// Latency: a full word leaves one eth_rx_clk after its last nibble; a partial final word leaves on the first dv-low edge.
// No backpressure: every beat is taken downstream. Optional FCS check is built when ETH_RX_FCS_CHECK_EN is defined.
module ethernet_rx_framer #(
    parameter int DATA_BYTES    = 1,
    parameter int PRE_MIN_BYTES = 2,
    parameter int MIN_LEN       = 64,
    parameter int MAX_LEN       = 1518
) (
    input  logic                    eth_rx_clk,
    input  logic                    eth_rx_rst_n,
    input  logic                    eth_rx_dv,
    input  logic                    eth_rxerr,
    input  logic [3:0]              eth_rxd,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic [DATA_BYTES-1:0]   rx_keep,
    output logic                    rx_valid,
    output logic                    rx_sof,
    output logic                    rx_eof,
    output logic [3:0]              rx_status,
    output logic [15:0]             rx_frame_len,
    output logic                    rx_drop
);
    localparam int LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
    state_t state, state_nxt;

    logic                    dv_prev;
    logic                    phase;
    logic [3:0]              lo_nib;
    logic [7:0]              pre_cnt;
    logic [LW-1:0]           lane_idx;
    logic [8*DATA_BYTES-1:0] lane_word;
    logic [8*DATA_BYTES-1:0] pend_word;
    logic                    pend_vld;
    logic                    sof_pend;
    logic                    mii_err;
    logic [15:0]             byte_cnt;
    logic                    crc_err;

    logic                    byte_done;
    logic [7:0]              rx_byte;
    logic [8*DATA_BYTES-1:0] word_nxt;
    logic [DATA_BYTES-1:0]   tail_keep;
    logic                    frame_end;
    logic                    drop_now;
    logic [3:0]              eof_status;

    assign byte_done  = eth_rx_dv && phase;
    assign rx_byte    = {eth_rxd, lo_nib};
    // phase still holds the parity of the nibble count on the dv-low edge
    assign eof_status = {crc_err,
                         (int'(byte_cnt) < MIN_LEN) || (int'(byte_cnt) > MAX_LEN),
                         phase, mii_err};

    always_comb begin
        word_nxt  = lane_word;
        tail_keep = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (LW'(i) == lane_idx) word_nxt[8*i +: 8] = rx_byte;
            if (LW'(i) < lane_idx)  tail_keep[i] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        drop_now  = 1'b0;
        case (state)
            IDLE: if (eth_rx_dv && !dv_prev) state_nxt = PREAMBLE;
            PREAMBLE: begin
                if (!eth_rx_dv) begin
                    state_nxt = IDLE;
                    drop_now  = 1'b1;
                end else if (eth_rxerr) begin
                    state_nxt = DROP;
                end else if (byte_done && rx_byte != 8'h55) begin
                    state_nxt = (rx_byte == 8'hD5 && int'(pre_cnt) >= PRE_MIN_BYTES) ? DATA : DROP;
                end
            end
            DATA: if (!eth_rx_dv) begin
                state_nxt = IDLE;
                frame_end = (byte_cnt != 16'd0);
                drop_now  = (byte_cnt == 16'd0);
            end
            DROP: if (!eth_rx_dv) begin
                state_nxt = IDLE;
                drop_now  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge eth_rx_clk or negedge eth_rx_rst_n) begin
        if (!eth_rx_rst_n) begin
            state        <= IDLE;
            dv_prev      <= 1'b1;
            phase        <= 1'b0;
            lo_nib       <= '0;
            pre_cnt      <= '0;
            lane_idx     <= '0;
            lane_word    <= '0;
            pend_word    <= '0;
            pend_vld     <= 1'b0;
            sof_pend     <= 1'b0;
            mii_err      <= 1'b0;
            byte_cnt     <= '0;
            rx_data      <= '0;
            rx_keep      <= '0;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            rx_eof       <= 1'b0;
            rx_status    <= '0;
            rx_frame_len <= '0;
            rx_drop      <= 1'b0;
        end else begin
            state    <= state_nxt;
            dv_prev  <= eth_rx_dv;
            phase    <= eth_rx_dv && !phase;
            if (eth_rx_dv && !phase) lo_nib <= eth_rxd;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_drop  <= drop_now;

            if (state != PREAMBLE) pre_cnt <= '0;
            else if (byte_done && rx_byte == 8'h55 && pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;

            if (state != DATA) begin
                lane_idx  <= '0;
                lane_word <= '0;
                pend_vld  <= 1'b0;
                sof_pend  <= 1'b1;
                mii_err   <= 1'b0;
                byte_cnt  <= '0;
            end else begin
                if (eth_rx_dv && eth_rxerr) mii_err <= 1'b1;
                if (pend_vld) begin
                    rx_valid <= 1'b1;
                    rx_sof   <= sof_pend;
                    rx_eof   <= frame_end;
                    rx_data  <= pend_word;
                    rx_keep  <= '1;
                    sof_pend <= 1'b0;
                    pend_vld <= 1'b0;
                end else if (frame_end) begin
                    // Tail beat; keep is empty when a trailing odd nibble followed a full word
                    rx_valid <= 1'b1;
                    rx_sof   <= sof_pend;
                    rx_eof   <= 1'b1;
                    rx_data  <= lane_word;
                    rx_keep  <= tail_keep;
                    sof_pend <= 1'b0;
                end
                if (frame_end) begin
                    rx_status    <= eof_status;
                    rx_frame_len <= byte_cnt;
                end
                if (byte_done) begin
                    if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                    if (lane_idx == LANE_LAST) begin
                        pend_word <= word_nxt;
                        pend_vld  <= 1'b1;
                        lane_word <= '0;
                        lane_idx  <= '0;
                    end else begin
                        lane_word <= word_nxt;
                        lane_idx  <= lane_idx + LW'(1);
                    end
                end
            end
        end
    end

`ifdef ETH_RX_FCS_CHECK_EN
    // Right-shifting register: 0xDEBB20E3 is the residue 0xC704DD7B in this bit order
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    logic [31:0] crc;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc ^ {24'd0, rx_byte};
        for (int b = 0; b < 8; b++)
            crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
    end

    always_ff @(posedge eth_rx_clk or negedge eth_rx_rst_n) begin
        if (!eth_rx_rst_n)     crc <= '1;
        else if (state != DATA) crc <= '1;
        else if (byte_done)    crc <= crc_nxt;
    end

    assign crc_err = (crc != CRC_RESIDUE);
`else
    assign crc_err = 1'b0;
`endif

endmodule
